// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer and the accumulator datapath:
// state encoding, opcode constants, default widths and word-field helpers.
package instr_seq_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        DONE  = 3'd4,
        HOLD  = 3'd5
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_HALF = 2'b11;

    function automatic logic [1:0] get_opcode(input logic [7:0] word);
        return word[7:6];
    endfunction

    function automatic logic [5:0] get_operand(input logic [7:0] word);
        return word[5:0];
    endfunction

endpackage

// File: rtl/instr_seq_if.sv
// Program-memory read port plus the instruction valid/ready channel toward the datapath.
// master = sequencer side, slave = memory/datapath side.
interface instr_seq_if
    import instr_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output mem_rd_en, mem_addr, instr_out, instr_valid,
        input  mem_rdata, instr_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, instr_out, instr_valid,
        output mem_rdata, instr_ready
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetches words start_addr..end_addr (wrapping) from program memory and issues them in order.
// Optional single-step HOLD state and step input when INSTR_SEQ_STEP_EN is defined.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
`ifdef INSTR_SEQ_STEP_EN
    input  logic              step,
`endif
    instr_seq_if.master       bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   issue_cnt
);

    localparam logic [ADDR_W-1:0] PC_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_end;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W:0]   r_cnt;
    logic              r_rd_en;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    // Outputs are registered alongside the state: each transition loads the flags of the state it enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_end   <= '0;
            r_instr <= '0;
            r_cnt   <= '0;
            r_rd_en <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            if (abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_pc    <= start_addr;
                            r_end   <= end_addr;
                            r_cnt   <= '0;
                            r_state <= FETCH;
                            r_rd_en <= 1'b1;
                        end else begin
                            r_busy  <= 1'b0;
                        end
                    end
                    FETCH: r_state <= WAIT;
                    WAIT: begin
                        r_instr <= bus.mem_rdata;
`ifdef INSTR_SEQ_STEP_EN
                        r_state <= HOLD;
`else
                        r_state <= ISSUE;
                        r_valid <= 1'b1;
`endif
                    end
`ifdef INSTR_SEQ_STEP_EN
                    HOLD: begin
                        if (step) begin
                            r_state <= ISSUE;
                            r_valid <= 1'b1;
                        end
                    end
`endif
                    ISSUE: begin
                        if (bus.instr_ready) begin
                            r_cnt <= r_cnt + CNT_ONE;
                            if (r_pc == r_end) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_pc    <= r_pc + PC_ONE;
                                r_state <= FETCH;
                                r_rd_en <= 1'b1;
                            end
                        end else begin
                            r_valid <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mem_rd_en   = r_rd_en;
    assign bus.mem_addr    = r_pc;
    assign bus.instr_out   = r_instr;
    assign bus.instr_valid = r_valid;
    assign busy            = r_busy;
    assign done            = r_done;
    assign issue_cnt       = r_cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed runs push expected fetch addresses and
// issued words; a negedge monitor pops and compares on every fetch and every accepted word.
module tb_instr_sequencer;
    import instr_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] start_addr = 4'd0;
    logic [3:0] end_addr = 4'd0;
    logic       step = 1'b1;
    logic       busy;
    logic       done;
    logic [4:0] issue_cnt;

    instr_seq_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    instr_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .end_addr   (end_addr),
`ifdef INSTR_SEQ_STEP_EN
        .step       (step),
`endif
        .bus        (bus.master),
        .busy       (busy),
        .done       (done),
        .issue_cnt  (issue_cnt)
    );

    logic [7:0] mem [16];
    logic [7:0] exp_instr [$];
    logic [3:0] exp_addr [$];
    int         acc_cyc [$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         done_pulses = 0;
    logic [7:0] acc = 8'd0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_out = 8'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_rd_en) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_fetch: got addr %0d expected no fetch", bus.mem_addr);
                end else begin
                    chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
                end
            end
            if (prev_stall) begin
                chk("stall_valid_held", 32'(bus.instr_valid), 32'd1);
                chk("stall_stable", 32'(bus.instr_out), 32'(prev_out));
            end
            if (bus.instr_valid && bus.instr_ready && !abort) begin
                if (exp_instr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue: got %0h expected no issue", bus.instr_out);
                end else begin
                    chk("instr_out", 32'(bus.instr_out), 32'(exp_instr.pop_front()));
                end
                $display("issue word=%02h cyc=%0d cnt_before=%0d", bus.instr_out, cyc, issue_cnt);
                acc_cyc.push_back(cyc);
                case (get_opcode(bus.instr_out))
                    OP_LOAD: acc = {2'b00, get_operand(bus.instr_out)};
                    OP_ADD:  acc = acc + {2'b00, get_operand(bus.instr_out)};
                    OP_SUB:  acc = acc - {2'b00, get_operand(bus.instr_out)};
                    default: acc = acc >> 1;
                endcase
            end
            prev_stall = bus.instr_valid && !bus.instr_ready && !abort;
            prev_out   = bus.instr_out;
            if (done) done_pulses++;
        end
    end

    task automatic push_run(input int s, input int e);
        int len;
        len = ((e - s) & 15) + 1;
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(4'((s + i) & 15));
            exp_instr.push_back(mem[(s + i) & 15]);
        end
    endtask

    task automatic do_start(input int s, input int e, output int t0);
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = 4'(s);
        end_addr = 4'(e);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    task automatic wait_valid();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL valid_timeout: got no instr_valid expected one within 50 cycles");
        end
    endtask

    task automatic settle_and_check(input string tag, input int pulses_before, input int exp_pulses);
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, 32'(done_pulses - pulses_before), 32'(exp_pulses));
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_addr_q_empty"}, 32'(exp_addr.size()), 32'd0);
        chk({tag, "_instr_q_empty"}, 32'(exp_instr.size()), 32'd0);
    endtask

    initial begin
        int t0;
        int dc;
        int dp;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 8'h11);
        mem[2]  = 8'h05; mem[3]  = 8'h43; mem[4]  = 8'h82;
        mem[14] = 8'h0A; mem[15] = 8'h41; mem[0]  = 8'h81; mem[1]  = 8'hC0;
        mem[7]  = 8'h47;
        bus.instr_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_instr_out", 32'(bus.instr_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic run: 05,43,82 -> accumulator 6, 3-cycle cadence
        $display("run basic start=2 end=4");
        dp = done_pulses;
        push_run(2, 4);
        do_start(2, 4, t0);
        wait_done(dc);
        chk("basic_issue_cnt", 32'(issue_cnt), 32'd3);
        chk("basic_acc", 32'(acc), 32'd6);
        chk("basic_done_cycle", 32'(dc - t0), 32'd10);
        chk("basic_issue_count", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            chk("basic_first_latency", 32'(acc_cyc[0] - t0), 32'd3);
            chk("basic_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("basic_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end
        settle_and_check("basic", dp, 1);

        // Back-pressure on the second word
        $display("run backpressure start=2 end=4");
        dp = done_pulses;
        push_run(2, 4);
        do_start(2, 4, t0);
        wait_valid();
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
        wait_valid();
        chk("bp_word_held", 32'(bus.instr_out), 32'h43);
        chk("bp_cnt_mid", 32'(issue_cnt), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        bus.instr_ready = 1'b1;
        wait_done(dc);
        chk("bp_issue_cnt", 32'(issue_cnt), 32'd3);
        settle_and_check("bp", dp, 1);

        // Wrap through address 0
        $display("run wrap start=14 end=1");
        dp = done_pulses;
        push_run(14, 1);
        do_start(14, 1, t0);
        wait_done(dc);
        chk("wrap_issue_cnt", 32'(issue_cnt), 32'd4);
        settle_and_check("wrap", dp, 1);

        // Abort in ISSUE of the second word, with instr_ready high the same cycle
        $display("run abort start=2 end=4");
        dp = done_pulses;
        exp_addr.push_back(4'd2);
        exp_addr.push_back(4'd3);
        exp_instr.push_back(mem[2]);
        do_start(2, 4, t0);
        wait_valid();
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
        wait_valid();
        @(posedge clk); #1;
        abort = 1'b1;
        bus.instr_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_valid", 32'(bus.instr_valid), 32'd0);
        chk("abort_issue_cnt", 32'(issue_cnt), 32'd1);
        settle_and_check("abort", dp, 0);

        // Start while busy is ignored
        $display("run start_while_busy start=2 end=4");
        dp = done_pulses;
        push_run(2, 4);
        do_start(2, 4, t0);
        wait_valid();
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = 4'd9;
        end_addr = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(dc);
        chk("busy_start_issue_cnt", 32'(issue_cnt), 32'd3);
        settle_and_check("busy_start", dp, 1);

        // Single-instruction run
        $display("run single start=7 end=7");
        dp = done_pulses;
        push_run(7, 7);
        do_start(7, 7, t0);
        wait_done(dc);
        chk("single_issue_cnt", 32'(issue_cnt), 32'd1);
        chk("single_done_cycle", 32'(dc - t0), 32'd4);
        settle_and_check("single", dp, 1);

        // Asynchronous reset during FETCH
        $display("run reset_mid_fetch start=2 end=4");
        do_start(2, 4, t0);
        chk("fetch_rd_en", 32'(bus.mem_rd_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("arst_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_issue_cnt", 32'(issue_cnt), 32'd0);
        #1 rst = 1'b0;
        dp = done_pulses;
        push_run(2, 4);
        do_start(2, 4, t0);
        wait_done(dc);
        chk("post_rst_issue_cnt", 32'(issue_cnt), 32'd3);
        chk("post_rst_acc", 32'(acc), 32'd6);
        settle_and_check("post_rst", dp, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Controller that fetches 8-bit instruction words (opcode [7:6], operand [5:0]) from a synchronous-read program memory.
- Issues each word, in address order, to the accumulator output-logic datapath over a valid/ready handshake.
- Sits between program memory and the datapath. Sequences one program run per start pulse.

Parameters:
- ADDR_W, 4, program memory address width; program space is 2^ADDR_W words.
- DATA_W, 8, instruction word width. Must be 8 to match the datapath opcode/operand split.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run. Ignored unless the block is in IDLE.
- abort  in  1  synchronous cancel of a run in progress.
- start_addr  in  ADDR_W  first instruction address; latched on an accepted start.
- end_addr  in  ADDR_W  last instruction address, inclusive; latched on an accepted start.
- mem_rd_en  out  1  program memory read strobe.
- mem_addr  out  ADDR_W  program memory address.
- mem_rdata  in  DATA_W  read data; valid the cycle after mem_rd_en.
- instr_out  out  DATA_W  instruction word presented to the datapath.
- instr_valid  out  1  instr_out is valid.
- instr_ready  in  1  datapath accepts instr_out this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run completes normally.
- issue_cnt  out  ADDR_W+1  number of instructions accepted in the current or last run.

Behaviour:
- Reset (async, rst=1): state=IDLE, pc=0, instr_reg=0, issue_cnt=0. All outputs are 0.
- All outputs are Moore outputs, decoded from registered state, pc and instr_reg. There is no combinational path from any input to any output.
- FSM states and transitions:
  - IDLE: on start=1, latch start_addr and end_addr, set pc=start_addr, clear issue_cnt, go to FETCH. start while not IDLE has no effect.
  - FETCH: mem_rd_en=1, mem_addr=pc. Next state is WAIT.
  - WAIT: mem_rd_en=0. Capture mem_rdata into instr_reg. Next state is ISSUE.
  - ISSUE: instr_valid=1, instr_out=instr_reg, held stable until instr_ready=1.
    - On instr_ready=1: issue_cnt increments.
    - If pc==end_addr, go to DONE. Otherwise pc=pc+1 and go to FETCH.
  - DONE: done=1 for exactly one cycle, busy=1. Next state is IDLE.
- Latency and throughput:
  - First instr_valid occurs 3 cycles after the cycle in which start is accepted.
  - With instr_ready tied high, each instruction takes 3 cycles.
- Wrap-around: pc increments modulo 2^ADDR_W.
  - If end_addr < start_addr, the run wraps through address 0.
  - Run length is ((end_addr-start_addr) mod 2^ADDR_W)+1. start_addr==end_addr gives a single instruction.
  - issue_cnt is ADDR_W+1 bits wide, so a full 2^ADDR_W run counts without overflow.
- Abort:
  - abort=1 in any non-IDLE state forces IDLE on the next edge.
  - instr_valid drops that edge and done is not pulsed. issue_cnt holds its value.
  - abort has priority over instr_ready in ISSUE. The instruction is not counted even if instr_ready=1 in the same cycle.
- Simultaneous start and abort in IDLE: abort wins and start is ignored.
- Reset mid-run: asynchronous return to reset values. An in-flight memory read is discarded.
- mem_addr holds pc in all states. Only mem_rd_en qualifies the address.

Optional Feature:
- Macro: INSTR_SEQ_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and a state HOLD, entered from WAIT in place of ISSUE.
  - HOLD waits for step=1, then goes to ISSUE; instr_valid=0 while in HOLD.
  - abort in HOLD returns to IDLE.
- Undefined: no step port, no HOLD state, behaviour exactly as above.

Decomposition:
- Shared package instr_seq_pkg holds:
  - State encoding constants: IDLE, FETCH, WAIT, ISSUE, DONE, HOLD.
  - Opcode constants shared with the datapath: OP_LOAD=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_HALF=2'b11.
  - Default widths ADDR_W=4 and DATA_W=8.
- No sub-module required. The pc/issue counter could be split out but stays inline.

Test Plan:
- Basic run:
  - Stimulus: memory[2..4]=8'h05,8'h43,8'h82; start_addr=2, end_addr=4; instr_ready=1.
  - Response: instr_out sequence 05,43,82, each valid 1 cycle, 3 cycles apart; done pulses 1 cycle after the last issue; issue_cnt=3; downstream accumulator ends at 6.
- Back-pressure:
  - Stimulus: same program; hold instr_ready=0 for 4 cycles on the second instruction.
  - Response: instr_out=8'h43 stable with instr_valid=1 throughout; no extra mem_rd_en pulses; issue_cnt=3 at done.
- Wrap:
  - Stimulus: start_addr=14, end_addr=1.
  - Response: mem_addr reads 14,15,0,1; issue_cnt=4; done pulses once.
- Abort:
  - Stimulus: abort asserted in ISSUE of the 2nd instruction of a 3-instruction run, with instr_ready=1 in the same cycle.
  - Response: IDLE next cycle; busy=0, done=0, issue_cnt=1.
- Start while busy and single-instruction run:
  - Stimulus: a second start pulse mid-run; then a separate run with start_addr=end_addr=7.
  - Response: the mid-run start is ignored; the single run issues exactly one word with issue_cnt=1.
- Async reset mid-FETCH:
  - Stimulus: pulse rst during FETCH.
  - Response: all outputs 0 immediately, without waiting for a clock edge; the next start runs normally.
